// File: rtl/if_fetch_queue.sv
// Instruction-fetch stage: issues imem requests at pc_in, pairs in-order responses
// with their PCs and buffers {pc, instr} for decode; a flush discards all fetches.
module if_fetch_queue #(
    parameter int XLEN    = 32,
    parameter int DEPTH   = 4,
    parameter int MAX_OUT = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [XLEN-1:0]          pc_in,
    output logic                     pc_enable,
    output logic                     imem_req,
    output logic [XLEN-1:0]          imem_addr,
    input  logic                     imem_gnt,
    input  logic                     imem_rvalid,
    input  logic [XLEN-1:0]          imem_rdata,
    input  logic                     flush,
    output logic                     id_valid,
    input  logic                     id_ready,
    output logic [XLEN-1:0]          id_instr,
    output logic [XLEN-1:0]          id_pc,
    output logic [$clog2(DEPTH):0]   occupancy
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int PW = (MAX_OUT > 1) ? $clog2(MAX_OUT) : 1;
    localparam logic [CW-1:0] MAX_OUT_C = CW'(MAX_OUT);
    localparam logic [CW:0]   DEPTH_C   = (CW+1)'(DEPTH);

    logic [XLEN-1:0] q_pc_q    [DEPTH];
    logic [XLEN-1:0] q_instr_q [DEPTH];
    logic [XLEN-1:0] pend_pc_q [MAX_OUT];
    logic [AW-1:0]   head_q, head_d, tail_q, tail_d;
    logic [PW-1:0]   pend_wr_q, pend_wr_d, pend_rd_q, pend_rd_d;
    logic [CW-1:0]   occ_q, occ_d, outst_q, outst_d, drop_q, drop_d;

    logic            accept, rsp, rsp_keep, pop;
    logic [CW:0]     committed;

    function automatic logic [PW-1:0] pinc(input logic [PW-1:0] p);
        return (p == PW'(MAX_OUT - 1)) ? '0 : p + PW'(1);
    endfunction

    // Every accepted request already owns a queue slot, so responses never overflow.
    assign committed = {1'b0, occ_q} + {1'b0, outst_q};
    assign imem_req  = rst & ~flush & (outst_q < MAX_OUT_C) & (committed < DEPTH_C);
    assign accept    = imem_req & imem_gnt;
    assign pc_enable = accept;
    assign imem_addr = pc_in;

    assign rsp       = imem_rvalid & (outst_q != '0);
    assign rsp_keep  = rsp & (drop_q == '0) & ~flush;

    assign id_valid  = (occ_q != '0) & ~flush;
    assign pop       = id_valid & id_ready;
    assign id_pc     = q_pc_q[head_q];
    assign id_instr  = q_instr_q[head_q];
    assign occupancy = occ_q;

    always_comb begin
        head_d    = head_q;
        tail_d    = tail_q;
        occ_d     = occ_q;
        pend_wr_d = pend_wr_q;
        pend_rd_d = pend_rd_q;
        outst_d   = outst_q;
        drop_d    = drop_q;
        if (flush) begin
            // Everything still in flight after this cycle gets discarded on arrival.
            head_d    = '0;
            tail_d    = '0;
            occ_d     = '0;
            pend_wr_d = '0;
            pend_rd_d = '0;
            outst_d   = outst_q - CW'(rsp);
            drop_d    = outst_q - CW'(rsp);
        end else begin
            outst_d = outst_q + CW'(accept) - CW'(rsp);
            if (rsp && (drop_q != '0))
                drop_d = drop_q - CW'(1);
            if (accept)
                pend_wr_d = pinc(pend_wr_q);
            if (rsp_keep) begin
                pend_rd_d = pinc(pend_rd_q);
                tail_d    = tail_q + AW'(1);
            end
            if (pop)
                head_d = head_q + AW'(1);
            occ_d = occ_q + CW'(rsp_keep) - CW'(pop);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            head_q    <= '0;
            tail_q    <= '0;
            occ_q     <= '0;
            pend_wr_q <= '0;
            pend_rd_q <= '0;
            outst_q   <= '0;
            drop_q    <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                q_pc_q[i]    <= '0;
                q_instr_q[i] <= '0;
            end
            for (int i = 0; i < MAX_OUT; i++)
                pend_pc_q[i] <= '0;
        end else begin
            head_q    <= head_d;
            tail_q    <= tail_d;
            occ_q     <= occ_d;
            pend_wr_q <= pend_wr_d;
            pend_rd_q <= pend_rd_d;
            outst_q   <= outst_d;
            drop_q    <= drop_d;
            if (accept)
                pend_pc_q[pend_wr_q] <= pc_in;
            if (rsp_keep) begin
                q_pc_q[tail_q]    <= pend_pc_q[pend_rd_q];
                q_instr_q[tail_q] <= imem_rdata;
            end
        end
    end

endmodule

// File: tb/tb_if_fetch_queue.sv
// Directed bench for if_fetch_queue: small memory responder, PC model and
// hand-traced expected values per cycle.
module tb_if_fetch_queue;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] pc_in;
    logic        pc_enable, imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt, imem_rvalid;
    logic [31:0] imem_rdata;
    logic        flush;
    logic        id_valid, id_ready;
    logic [31:0] id_instr, id_pc;
    logic [2:0]  occupancy;

    int n_checks = 0;
    int n_errors = 0;
    int n_acc;
    logic auto_mem = 1'b0;
    logic bound_bad = 1'b0;

    if_fetch_queue #(.XLEN(32), .DEPTH(4), .MAX_OUT(2)) dut (
        .clk(clk), .rst(rst), .pc_in(pc_in), .pc_enable(pc_enable),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata), .flush(flush),
        .id_valid(id_valid), .id_ready(id_ready), .id_instr(id_instr),
        .id_pc(id_pc), .occupancy(occupancy)
    );

    always #5 clk = ~clk;

    always @(negedge clk)
        if (rst === 1'b1 && occupancy > 3'd4) bound_bad = 1'b1;

    function automatic logic [31:0] instr_of(input logic [31:0] pc);
        return {16'hC0DE, pc[15:0]};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // One clock: the memory model and PC model react to the accept seen this cycle.
    task automatic step();
        logic        acc;
        logic [31:0] a;
        #1;
        acc = pc_enable;
        a   = imem_addr;
        @(posedge clk);
        #1;
        if (acc) pc_in = pc_in + 32'd4;
        if (auto_mem) begin
            imem_rvalid = acc;
            imem_rdata  = acc ? instr_of(a) : 32'h0;
        end
    endtask

    task automatic do_reset();
        rst = 1'b0; auto_mem = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0;
        imem_gnt = 1'b0; flush = 1'b0; id_ready = 1'b0; pc_in = '0;
        @(posedge clk);
        #1;
        check("rst_idv", id_valid, 0);
        check("rst_occ", occupancy, 0);
        check("rst_req", imem_req, 0);
        check("rst_pc", id_pc, 0);
        rst = 1'b1;
    endtask

    initial begin
        // zero-wait memory, decode always ready
        do_reset();
        auto_mem = 1'b1; imem_gnt = 1'b1; id_ready = 1'b1;
        #1; check("t1_pe0", pc_enable, 1); check("t1_addr0", imem_addr, 32'h0);
        check("t1_idv0", id_valid, 0); step();
        #1; check("t1_pe1", pc_enable, 1); check("t1_addr1", imem_addr, 32'h4);
        check("t1_idv1", id_valid, 0); step();
        #1; check("t1_idv2", id_valid, 1); check("t1_pc2", id_pc, 32'h0);
        check("t1_instr2", id_instr, instr_of(32'h0)); check("t1_pe2", pc_enable, 1); step();
        #1; check("t1_pc3", id_pc, 32'h4); step();
        #1; check("t1_pc4", id_pc, 32'h8); check("t1_occ4", occupancy, 1); step();

        // decode stalled: reservation limits accepts to DEPTH
        do_reset();
        auto_mem = 1'b1; imem_gnt = 1'b1; id_ready = 1'b0; n_acc = 0;
        for (int i = 0; i < 8; i++) begin
            #1; if (pc_enable) n_acc++;
            step();
        end
        check("t2_accepts", n_acc, 4);
        id_ready = 1'b1;
        #1; check("t2_req_full", imem_req, 0); check("t2_occ_full", occupancy, 4);
        check("t2_d0", id_pc, 32'h0); step();
        #1; check("t2_d1", id_pc, 32'h4); check("t2_req_resume", imem_req, 1);
        check("t2_addr_resume", imem_addr, 32'h10); step();
        #1; check("t2_d2", id_pc, 32'h8); step();
        #1; check("t2_d3", id_pc, 32'hC); step();

        // grant withheld for three cycles
        do_reset();
        auto_mem = 1'b1; pc_in = 32'h40; id_ready = 1'b1; imem_gnt = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1; check("t3_req_wait", imem_req, 1); check("t3_pe_wait", pc_enable, 0);
            check("t3_addr_wait", imem_addr, 32'h40); step();
        end
        imem_gnt = 1'b1;
        #1; check("t3_pe_gnt", pc_enable, 1); step();
        imem_gnt = 1'b0;
        #1; check("t3_idv_lat", id_valid, 0); step();
        #1; check("t3_idv", id_valid, 1); check("t3_pc", id_pc, 32'h40); step();

        // flush with two outstanding and two queued
        do_reset();
        pc_in = 32'h8; id_ready = 1'b0; imem_gnt = 1'b1;
        #1; check("t4_pe_c0", pc_enable, 1); check("t4_addr_c0", imem_addr, 32'h8); step();
        #1; check("t4_pe_c1", pc_enable, 1); check("t4_addr_c1", imem_addr, 32'hC); step();
        imem_rvalid = 1'b1; imem_rdata = instr_of(32'h8);
        #1; check("t4_req_c2", imem_req, 0); step();
        imem_rvalid = 1'b1; imem_rdata = instr_of(32'hC);
        #1; check("t4_addr_c3", imem_addr, 32'h10); check("t4_pe_c3", pc_enable, 1); step();
        imem_rvalid = 1'b0;
        #1; check("t4_addr_c4", imem_addr, 32'h14); check("t4_occ_c4", occupancy, 2); step();
        flush = 1'b1;
        #1; check("t4_req_fl", imem_req, 0); check("t4_pe_fl", pc_enable, 0);
        check("t4_idv_fl", id_valid, 0); check("t4_occ_fl", occupancy, 2); step();
        flush = 1'b0; pc_in = 32'h100; imem_rvalid = 1'b1; imem_rdata = instr_of(32'h10);
        #1; check("t4_occ_after", occupancy, 0); check("t4_idv_after", id_valid, 0);
        check("t4_req_after", imem_req, 0); step();
        imem_rvalid = 1'b1; imem_rdata = instr_of(32'h14);
        #1; check("t4_pe_tgt", pc_enable, 1); check("t4_addr_tgt", imem_addr, 32'h100); step();
        imem_gnt = 1'b0; imem_rvalid = 1'b1; imem_rdata = instr_of(32'h100);
        #1; check("t4_occ_drop", occupancy, 0); check("t4_idv_drop", id_valid, 0); step();
        imem_rvalid = 1'b0; id_ready = 1'b1;
        #1; check("t4_idv_tgt", id_valid, 1); check("t4_pc_tgt", id_pc, 32'h100);
        check("t4_instr_tgt", id_instr, instr_of(32'h100)); check("t4_occ_tgt", occupancy, 1); step();
        #1; check("t4_occ_end", occupancy, 0); step();

        // flush coinciding with the only response
        do_reset();
        pc_in = 32'h20; imem_gnt = 1'b1;
        #1; check("t5_pe_c0", pc_enable, 1); step();
        imem_gnt = 1'b0; flush = 1'b1; imem_rvalid = 1'b1; imem_rdata = instr_of(32'h20);
        #1; check("t5_req_fl", imem_req, 0); step();
        flush = 1'b0; imem_rvalid = 1'b0; pc_in = 32'h200; imem_gnt = 1'b1;
        #1; check("t5_occ", occupancy, 0); check("t5_idv", id_valid, 0);
        check("t5_pe_tgt", pc_enable, 1); step();
        imem_gnt = 1'b0; imem_rvalid = 1'b1; imem_rdata = instr_of(32'h200);
        #1; check("t5_no_stale", id_valid, 0); step();
        imem_rvalid = 1'b0;
        #1; check("t5_idv_tgt", id_valid, 1); check("t5_pc_tgt", id_pc, 32'h200); step();

        // asynchronous reset mid-stream
        do_reset();
        auto_mem = 1'b1; imem_gnt = 1'b1; id_ready = 1'b0;
        for (int i = 0; i < 4; i++) step();
        #1; check("t6_occ3", occupancy, 3);
        rst = 1'b0;
        #1; check("t6_occ_rst", occupancy, 0); check("t6_idv_rst", id_valid, 0);
        check("t6_req_rst", imem_req, 0); check("t6_pe_rst", pc_enable, 0);
        check("t6_pc_rst", id_pc, 0); check("t6_instr_rst", id_instr, 0);
        step();
        rst = 1'b1; auto_mem = 1'b0; imem_gnt = 1'b0;
        imem_rvalid = 1'b1; imem_rdata = 32'hDEAD_BEEF;
        step();
        imem_rvalid = 1'b0;
        #1; check("t6_stray_occ", occupancy, 0); check("t6_stray_idv", id_valid, 0); step();
        #1; check("t6_stray_occ2", occupancy, 0);

        check("occ_bound", bound_bad, 0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/if_fetch_queue.md
Name: if_fetch_queue

Overview:
Instruction-fetch stage directly downstream of the PC register and upstream of the IF/ID boundary. It issues instruction-memory requests at the current PC and pairs each in-order response with its PC. Fetched {pc, instr} pairs are buffered in a DEPTH-entry queue that decode drains with a valid/ready handshake. It generates the PC load-enable and discards all queued and in-flight fetches on a branch/jump flush.

Parameters:
XLEN, 32, width of PC and instruction word
DEPTH, 4, fetch-queue entries (power of 2, >= 2)
MAX_OUT, 2, maximum outstanding imem requests (1 <= MAX_OUT <= DEPTH)

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-low reset
pc_in  in  XLEN  current PC register value
pc_enable  out  1  PC load strobe (PC+4 path), high when a request is accepted
imem_req  out  1  fetch request valid
imem_addr  out  XLEN  fetch address (= pc_in)
imem_gnt  in  1  memory accepts request this cycle
imem_rvalid  in  1  response valid (in order, >= 1 cycle after grant)
imem_rdata  in  XLEN  response instruction
flush  in  1  redirect from EX; discard everything
id_valid  out  1  head entry valid for decode
id_ready  in  1  decode accepts head entry
id_instr  out  XLEN  head instruction
id_pc  out  XLEN  head PC
occupancy  out  log2(DEPTH)+1  valid queue entries

Behaviour:
- Reset (rst=0, async): queue, pending-PC FIFO, outstanding and drop counters cleared. id_valid=0, id_instr=0, id_pc=0, occupancy=0, imem_req=0, pc_enable=0.
- Reservation: imem_req = !flush & (outstanding < MAX_OUT) & (occupancy + outstanding < DEPTH). This guarantees room for every live response, so the queue can never overflow.
- imem_addr = pc_in (combinational). Handshake completes on imem_req & imem_gnt. pc_enable equals exactly that product in the same cycle.
- On accept: pc_in is pushed into the pending-PC FIFO (MAX_OUT entries), and outstanding increments.
- On imem_rvalid with outstanding>0: outstanding decrements.
  - If drop>0: the response is discarded and drop decrements.
  - Otherwise: the pending-PC head is popped, and {pc, imem_rdata} is written into the queue tail (registered).
- imem_rvalid with outstanding==0 is ignored; no state changes.
- Accept and response in the same cycle: outstanding is unchanged net.
- Output: id_valid = (occupancy != 0) & !flush. id_instr/id_pc are driven combinationally from head storage. Pop on id_valid & id_ready.
- Push and pop in the same cycle: occupancy is unchanged. Push into an empty queue becomes visible the next cycle (no bypass).
- Minimum latency: grant in cycle N, rvalid in N+1, id_valid in N+2.
- Flush (single cycle, has priority over everything):
  - Queue and pending-PC FIFO are cleared next cycle.
  - No request is issued (imem_req=0, pc_enable=0).
  - drop <= outstanding minus 1 if rvalid is present this cycle; a response arriving in the flush cycle is itself discarded.
  - The top level loads the branch target into PC independently.
  - Fetching resumes the cycle after flush at the new pc_in. New requests may issue while drop>0; their responses follow the dropped ones in order.
- Back-to-back flushes: drop is recomputed from live outstanding each time and never double-counts.
- Pointers wrap modulo DEPTH. Counters never exceed DEPTH / MAX_OUT. The bench asserts this.
- Reset mid-operation: immediate clear. In-flight responses after reset are ignored because outstanding=0.

Test Plan:
- Zero-wait memory (gnt=1, rvalid one cycle later), id_ready=1, pc_in stepping 0x0,0x4,0x8. Required: pc_enable every cycle; id_pc=0x0 with id_instr=rdata two cycles after first grant, then one entry per cycle.
- id_ready=0 with continuous grants. Required: exactly DEPTH=4 accepts, then imem_req=0 and occupancy=4. Raising id_ready drains 0x0..0xC in order, and requests resume.
- gnt held 0 for 3 cycles. Required: imem_req stays 1, pc_enable=0, imem_addr stable; accept on the first gnt=1.
- Two outstanding (0x10, 0x14) plus 2 queued, then flush. Required: occupancy=0 and id_valid=0 next cycle; both late responses are discarded. The first request after flush fetches target 0x100, and id_pc=0x100 is the next entry delivered.
- Flush in the same cycle as rvalid with 1 outstanding. Required: that response is dropped, drop=0, no stale entry appears.
- Assert rst=0 mid-stream with occupancy=3. Required: all outputs zero asynchronously. A stray rvalid after release is ignored (occupancy stays 0).
